m68k_bus_master: RTL and testbench

- Bus initiator for the Mackerel 68000-style asynchronous bus.
- Converts a simple valid/ready request port into a complete bus cycle: it drives ADDR, RW, AS, UDS and LDS, waits for DTACK or BERR, then returns read data or an error.
- Sits beside the CPU as a second bus master (DMA or debug access). It targets the same decoded ROM, RAM and MFP responders.
- Bus arbitration (BR/BG/BGACK) is outside this block.

---
 rtl/m68k_bus_master.sv | 200 ++++++++++++++++++++
 tb/tb_m68k_bus_master.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m68k_bus_master.sv
// Second bus master for the Mackerel 68000-style asynchronous bus: turns a
// valid/ready request into one ADDR/AS/UDS/LDS cycle terminated by DTACK, BERR or a timeout.
module m68k_bus_master #(
    parameter int ADDR_W      = 23,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_be,
    input  logic [15:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [15:0]       resp_rdata,
    output logic [ADDR_W-1:0] ADDR,
    output logic              RW,
    output logic              AS,
    output logic              UDS,
    output logic              LDS,
    output logic [15:0]       DATA_OUT,
    output logic              DATA_OE,
    input  logic [15:0]       DATA_IN,
    input  logic              DTACK,
    input  logic              BERR
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_STROBE,
        ST_WAIT,
        ST_LATCH,
        ST_RECOVER
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t               state_reg;
    logic [7:0]           timer_reg;
    logic                 rw_reg;
    logic [1:0]           be_reg;
    logic [ADDR_W-1:0]    addr_reg;
    logic [15:0]          wdata_reg;
    logic                 err_reg;

    logic [SYNC_STAGES-1:0] dtack_sync_reg;
    logic [SYNC_STAGES-1:0] berr_sync_reg;
    logic                   dtack_s;
    logic                   berr_s;

    // Responder handshakes are asynchronous; presetting to 1 keeps a reset
    // from looking like an acknowledge.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge CLK or posedge RST) begin
                    if (RST) begin
                        dtack_sync_reg[gi] <= 1'b1;
                        berr_sync_reg[gi]  <= 1'b1;
                    end else begin
                        dtack_sync_reg[gi] <= DTACK;
                        berr_sync_reg[gi]  <= BERR;
                    end
                end
            end else begin : g_next
                always_ff @(posedge CLK or posedge RST) begin
                    if (RST) begin
                        dtack_sync_reg[gi] <= 1'b1;
                        berr_sync_reg[gi]  <= 1'b1;
                    end else begin
                        dtack_sync_reg[gi] <= dtack_sync_reg[gi-1];
                        berr_sync_reg[gi]  <= berr_sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign dtack_s = dtack_sync_reg[SYNC_STAGES-1];
    assign berr_s  = berr_sync_reg[SYNC_STAGES-1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg  <= ST_IDLE;
            timer_reg  <= 8'd0;
            rw_reg     <= 1'b1;
            be_reg     <= 2'b00;
            addr_reg   <= '0;
            wdata_reg  <= 16'd0;
            err_reg    <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 16'd0;
            ADDR       <= '0;
            RW         <= 1'b1;
            AS         <= 1'b1;
            UDS        <= 1'b1;
            LDS        <= 1'b1;
            DATA_OUT   <= 16'd0;
            DATA_OE    <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        if (req_be == 2'b00) begin
                            // Nothing to strobe: reject without touching the bus.
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            rw_reg    <= req_rw;
                            be_reg    <= req_be;
                            addr_reg  <= req_addr;
                            wdata_reg <= req_wdata;
                            req_ready <= 1'b0;
                            state_reg <= ST_ADDR;
                        end
                    end
                end

                ST_ADDR: begin
                    ADDR <= addr_reg;
                    RW   <= rw_reg;
                    if (!rw_reg) begin
                        DATA_OUT <= wdata_reg;
                        DATA_OE  <= 1'b1;
                    end
                    state_reg <= ST_STROBE;
                end

                ST_STROBE: begin
                    AS        <= 1'b0;
                    UDS       <= ~be_reg[1];
                    LDS       <= ~be_reg[0];
                    timer_reg <= 8'd0;
                    state_reg <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (!berr_s) begin
                        err_reg   <= 1'b1;
                        state_reg <= ST_LATCH;
                    end else if (!dtack_s) begin
                        err_reg   <= 1'b0;
                        state_reg <= ST_LATCH;
                    end else if (timer_reg == TIMER_LAST) begin
                        err_reg   <= 1'b1;
                        state_reg <= ST_LATCH;
                    end else begin
                        timer_reg <= timer_reg + 8'd1;
                    end
                end

                ST_LATCH: begin
                    if (rw_reg && !err_reg) begin
                        resp_rdata <= DATA_IN;
                    end
                    AS         <= 1'b1;
                    UDS        <= 1'b1;
                    LDS        <= 1'b1;
                    resp_valid <= 1'b1;
                    resp_err   <= err_reg;
                    timer_reg  <= 8'd0;
                    state_reg  <= ST_RECOVER;
                end

                ST_RECOVER: begin
                    // Write data stays driven one cycle past strobe negation.
                    DATA_OE <= 1'b0;
                    RW      <= 1'b1;
                    if (dtack_s && berr_s) begin
                        req_ready <= 1'b1;
                        timer_reg <= 8'd0;
                        state_reg <= ST_IDLE;
                    end else if (timer_reg == TIMER_LAST) begin
                        req_ready <= 1'b1;
                        timer_reg <= 8'd0;
                        state_reg <= ST_IDLE;
                    end else begin
                        timer_reg <= timer_reg + 8'd1;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_bus_master.sv
// Bench for m68k_bus_master: directed table, reset-in-WAIT sequence and random
// transactions against a timing-level reference model and a behavioural responder.
module tb_m68k_bus_master;

    localparam int AW   = 23;
    localparam int SYNC = 2;
    localparam int TMO  = 16;

    localparam int M_ACK  = 0;
    localparam int M_NONE = 1;
    localparam int M_BERR = 2;
    localparam int M_BOTH = 3;

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [1:0]    be;
        logic [15:0]   wdata;
        int            mode;
        int            delay;
        int            hold;
        logic [15:0]   bus_data;
        logic          exp_err;
        logic [15:0]   exp_rdata;
        int            exp_lat;
        int            exp_rdy;
    } vec_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_rw = 1'b1;
    logic [AW-1:0] req_addr = '0;
    logic [1:0]    req_be = 2'b00;
    logic [15:0]   req_wdata = 16'h0;
    logic          resp_valid;
    logic          resp_err;
    logic [15:0]   resp_rdata;
    logic [AW-1:0] ADDR;
    logic          RW, AS, UDS, LDS;
    logic [15:0]   DATA_OUT;
    logic          DATA_OE;
    logic [15:0]   DATA_IN = 16'h0;
    logic          DTACK = 1'b1;
    logic          BERR = 1'b1;

    int            checks = 0;
    int            errors = 0;

    int            rsp_mode = M_NONE;
    int            rsp_delay = 0;
    int            rsp_hold = 1;
    logic [15:0]   rsp_data = 16'h0;
    int            seen = 0;
    int            bheld = 0;

    logic [15:0]   last_rdata = 16'h0;
    vec_t          tbl [9];

    m68k_bus_master #(
        .ADDR_W(AW),
        .SYNC_STAGES(SYNC),
        .TIMEOUT(TMO)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .ADDR(ADDR), .RW(RW), .AS(AS), .UDS(UDS), .LDS(LDS),
        .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .DATA_IN(DATA_IN),
        .DTACK(DTACK), .BERR(BERR)
    );

    always #5 CLK = ~CLK;

    // Responder: reacts on the first edge after it sees AS low (plus rsp_delay),
    // holds data until AS negates, and keeps BERR low for at least rsp_hold edges.
    always @(posedge CLK) begin
        if (!AS) begin
            seen <= seen + 1;
            if (seen == rsp_delay) begin
                if (rsp_mode == M_ACK || rsp_mode == M_BOTH) begin
                    DTACK   <= 1'b0;
                    DATA_IN <= rsp_data;
                end
                if (rsp_mode == M_BERR || rsp_mode == M_BOTH) BERR <= 1'b0;
            end
        end else begin
            seen    <= 0;
            DTACK   <= 1'b1;
            DATA_IN <= ~rsp_data;
        end
        if (!BERR) begin
            bheld <= bheld + 1;
            if (AS && (bheld + 1 >= rsp_hold)) BERR <= 1'b1;
        end else begin
            bheld <= 0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Edge numbers count from the accepting edge E0; an output registered at En
    // is observed at the negedge following En.
    function automatic vec_t model(input vec_t v, input logic [15:0] prev);
        vec_t r;
        int as_edge, ack_edge, rel_edge;
        r = v;
        r.exp_rdata = prev;
        as_edge  = 2;
        ack_edge = as_edge + 1 + v.delay;
        if (v.be == 2'b00) begin
            r.exp_err = 1'b1;
            r.exp_lat = 0;
            r.exp_rdy = 0;
        end else if (v.mode == M_NONE) begin
            r.exp_err = 1'b1;
            r.exp_lat = as_edge + TMO + 1;
            r.exp_rdy = r.exp_lat + 1;
        end else begin
            r.exp_lat = ack_edge + SYNC + 2;
            r.exp_err = (v.mode != M_ACK);
            if (v.mode == M_ACK && v.rw) r.exp_rdata = v.bus_data;
            rel_edge = r.exp_lat + 1;
            if (v.mode != M_ACK && ack_edge + v.hold > rel_edge) rel_edge = ack_edge + v.hold;
            r.exp_rdy = rel_edge + SYNC + 1;
            if (r.exp_lat + TMO < r.exp_rdy) r.exp_rdy = r.exp_lat + TMO;
        end
        return r;
    endfunction

    task automatic run_txn(input vec_t v, input int idx);
        int n, last_n, wait_cnt, resp_idx, first_as, rdy_idx, npulse, bus_bad;
        logic cap_err;
        logic [15:0] cap_rdata, neg_dout;
        logic [2:0] e1_sig, neg_sig;
        logic neg_oe;
        logic [1:0] rec_sig;
        cap_err = 1'b0; cap_rdata = 16'h0; neg_dout = 16'h0;
        e1_sig = 3'b000; neg_sig = 3'b000; neg_oe = 1'b0; rec_sig = 2'b00;
        resp_idx = -1; first_as = -1; rdy_idx = -1; npulse = 0; bus_bad = 0;

        wait_cnt = 0;
        while (!req_ready && wait_cnt < 100) begin
            @(negedge CLK);
            wait_cnt++;
        end
        check("ready_before_req", req_ready, 1'b1);

        rsp_mode  = v.mode;
        rsp_delay = v.delay;
        rsp_hold  = v.hold;
        rsp_data  = v.bus_data;
        req_rw    = v.rw;
        req_addr  = v.addr;
        req_be    = v.be;
        req_wdata = v.wdata;
        req_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        req_rw    = 1'($urandom);
        req_addr  = AW'($urandom);
        req_be    = 2'($urandom);
        req_wdata = 16'($urandom);

        last_n = ((v.exp_lat > v.exp_rdy) ? v.exp_lat : v.exp_rdy) + 2;
        for (n = 0; n <= last_n && n < 200; n++) begin
            if (n > 0) @(negedge CLK);
            if (resp_valid) begin
                npulse++;
                if (resp_idx < 0) begin
                    resp_idx  = n;
                    cap_err   = resp_err;
                    cap_rdata = resp_rdata;
                    neg_sig   = {AS, UDS, LDS};
                    neg_oe    = DATA_OE;
                    neg_dout  = DATA_OUT;
                end
            end
            if (!AS) begin
                if (first_as < 0) first_as = n;
                if ({UDS, LDS} != ~v.be || RW != v.rw || ADDR != v.addr ||
                    DATA_OE != !v.rw || (!v.rw && DATA_OUT != v.wdata)) bus_bad++;
            end
            if (n == 1) e1_sig = {AS, RW, DATA_OE};
            if (resp_idx >= 0 && n == resp_idx + 1) rec_sig = {DATA_OE, RW};
            if (req_ready && rdy_idx < 0) rdy_idx = n;
        end

        check("resp_latency", resp_idx, v.exp_lat);
        check("resp_pulses", npulse, 1);
        check("resp_err", cap_err, v.exp_err);
        check("resp_rdata", cap_rdata, v.exp_rdata);
        check("ready_latency", rdy_idx, v.exp_rdy);
        check("bus_fields_bad", bus_bad, 0);
        if (v.be == 2'b00) begin
            check("as_quiet", first_as, -1);
        end else begin
            check("as_fall_edge", first_as, 2);
            check("addr_phase", e1_sig, {1'b1, v.rw, ~v.rw});
            check("strobe_negate", {neg_sig, neg_oe}, {3'b111, ~v.rw});
            if (!v.rw) check("wdata_hold", neg_dout, v.wdata);
            check("recover_release", rec_sig, 2'b01);
        end
        $display("txn %0d rw=%0b addr=%h be=%b mode=%0d dly=%0d hold=%0d lat=%0d rdy=%0d err=%0b rdata=%h",
                 idx, v.rw, v.addr, v.be, v.mode, v.delay, v.hold, resp_idx, rdy_idx, cap_err, cap_rdata);
    endtask

    initial begin
        vec_t v;
        int npulse;

        #1 RST = 1'b1;
        #2;
        check("reset_ctrl", {AS, UDS, LDS, RW, DATA_OE, req_ready, resp_valid, resp_err}, 8'b1111_0100);
        check("reset_data", {ADDR, DATA_OUT, resp_rdata}, '0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("ready_after_reset", req_ready, 1'b1);

        tbl[0] = '{rw:1'b1, addr:23'h1FC000, be:2'b11, wdata:16'h0000, mode:M_ACK,  delay:0, hold:1,
                   bus_data:16'hBEEF, exp_err:1'b0, exp_rdata:16'hBEEF, exp_lat:7,  exp_rdy:11};
        tbl[1] = '{rw:1'b0, addr:23'h000100, be:2'b10, wdata:16'h1234, mode:M_ACK,  delay:0, hold:1,
                   bus_data:16'h0000, exp_err:1'b0, exp_rdata:16'hBEEF, exp_lat:7,  exp_rdy:11};
        tbl[2] = '{rw:1'b1, addr:23'h7FFFFF, be:2'b01, wdata:16'h0000, mode:M_NONE, delay:0, hold:1,
                   bus_data:16'h3333, exp_err:1'b1, exp_rdata:16'hBEEF, exp_lat:19, exp_rdy:20};
        tbl[3] = '{rw:1'b1, addr:23'h000200, be:2'b11, wdata:16'h0000, mode:M_BOTH, delay:0, hold:1,
                   bus_data:16'h1111, exp_err:1'b1, exp_rdata:16'hBEEF, exp_lat:7,  exp_rdy:11};
        tbl[4] = '{rw:1'b0, addr:23'h000300, be:2'b11, wdata:16'hCAFE, mode:M_BERR, delay:0, hold:10,
                   bus_data:16'h2222, exp_err:1'b1, exp_rdata:16'hBEEF, exp_lat:7,  exp_rdy:16};
        tbl[5] = '{rw:1'b1, addr:23'h000400, be:2'b00, wdata:16'h0000, mode:M_ACK,  delay:0, hold:1,
                   bus_data:16'h4444, exp_err:1'b1, exp_rdata:16'hBEEF, exp_lat:0,  exp_rdy:0};
        tbl[6] = '{rw:1'b1, addr:23'h000000, be:2'b01, wdata:16'h0000, mode:M_ACK,  delay:3, hold:1,
                   bus_data:16'h5A5A, exp_err:1'b0, exp_rdata:16'h5A5A, exp_lat:10, exp_rdy:14};
        tbl[7] = '{rw:1'b1, addr:23'h012345, be:2'b10, wdata:16'h0000, mode:M_BERR, delay:1, hold:20,
                   bus_data:16'h7777, exp_err:1'b1, exp_rdata:16'h5A5A, exp_lat:8,  exp_rdy:24};
        tbl[8] = '{rw:1'b0, addr:23'h054321, be:2'b01, wdata:16'h00FF, mode:M_NONE, delay:0, hold:1,
                   bus_data:16'h8888, exp_err:1'b1, exp_rdata:16'h5A5A, exp_lat:19, exp_rdy:20};

        for (int i = 0; i < 9; i++) begin
            run_txn(tbl[i], i);
            last_rdata = tbl[i].exp_rdata;
        end

        // Reset while a write sits in WAIT with no responder.
        rsp_mode  = M_NONE;
        req_rw    = 1'b0;
        req_addr  = 23'h0ABCDE;
        req_be    = 2'b11;
        req_wdata = 16'hA5A5;
        req_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        repeat (4) @(negedge CLK);
        check("pre_reset_in_wait", {AS, DATA_OE, req_ready}, 3'b010);
        #2 RST = 1'b1;
        #1;
        check("async_reset_bus", {AS, UDS, LDS, DATA_OE, req_ready, resp_valid}, 6'b111010);
        #1 RST = 1'b0;
        npulse = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (resp_valid) npulse++;
        end
        check("no_resp_after_reset", npulse, 0);
        check("rdata_after_reset", resp_rdata, 16'h0000);
        last_rdata = 16'h0000;
        v = '{rw:1'b1, addr:23'h1FC000, be:2'b11, wdata:16'h0000, mode:M_ACK, delay:0, hold:1,
              bus_data:16'h0F0F, exp_err:1'b0, exp_rdata:16'h0F0F, exp_lat:7, exp_rdy:11};
        run_txn(v, 100);
        last_rdata = v.exp_rdata;

        for (int i = 0; i < 40; i++) begin
            int r;
            v.rw       = 1'($urandom);
            v.addr     = AW'($urandom);
            v.be       = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            v.wdata    = 16'($urandom);
            r          = $urandom_range(0, 9);
            v.mode     = (r <= 5) ? M_ACK : (r == 6) ? M_NONE : (r == 7) ? M_BERR : M_BOTH;
            v.delay    = $urandom_range(0, 6);
            v.hold     = $urandom_range(1, 20);
            v.bus_data = 16'($urandom);
            v = model(v, last_rdata);
            run_txn(v, 200 + i);
            last_rdata = v.exp_rdata;
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
